mtpsa_from_sdnet: RTL and testbench
===================================

// Module: mtpsa_from_sdnet
// PURPOSE
// - Return-path adapter between user0Switch packet/tuple outputs and the SUME AXI4-Stream master.
// - SDNet emits metadata and digest tuples as single-cycle VALID pulses; SUME requires m_axis_tuser held on every beat.
// - Queues tuples, pairs each with the next packet, and holds tuser = {digest, metadata[47:0]} stable from first beat to tlast.
// - Sits between user0Switch and the output queues, mirroring the input-side tuple-VALID generator.
// PARAMETERS
// - C_AXIS_DATA_WIDTH    256  tdata width; tkeep = /8
// - C_META_WIDTH         128  tuple_out_mtpsa_metadata_DATA width
// - DIGEST_WIDTH         256  tuple_out_digest_data_DATA width
// - C_M_AXIS_TUSER_WIDTH 304  = DIGEST_WIDTH + 48
// - TUPLE_DEPTH          4    tuple queue entries, power of 2, >=2
// PORTS
// - axis_aclk            in   1    single clock, all logic
// - axis_rst             in   1    synchronous, active-high reset
// - sdnet_tvalid/tlast   in   1    SDNet packet_out valid/last
// - sdnet_tdata          in   256  SDNet packet_out data
// - sdnet_tkeep          in   32   SDNet packet_out keep
// - sdnet_tready         out  1    to SDNet packet_out_TREADY
// - meta_valid           in   1    tuple_out_mtpsa_metadata_VALID, 1-cycle pulse per packet
// - meta_data            in   128  tuple_out_mtpsa_metadata_DATA
// - digest_data          in   256  tuple_out_digest_data_DATA, sampled with meta_valid
// - m_axis_tdata/tkeep   out  256/32  to SUME
// - m_axis_tuser         out  304  {digest, meta[47:0]}, stable for whole packet
// - m_axis_tvalid/tlast  out  1    to SUME
// - m_axis_tready        in   1    from SUME
// - tuple_ovfl           out  1    sticky: tuple arrived while queue full (dropped)
// - pkt_cnt              out  32   packets forwarded (tlast handshakes), wraps
// BEHAVIOUR
// - Reset: queue empty, state WAIT_SOP, tuple_ovfl=0, pkt_cnt=0. m_axis_tvalid=0 and sdnet_tready=0 in the reset cycle and the first cycle after it.
// - Push: meta_valid=1 writes {digest_data, meta_data[47:0]} at the tail. The entry is visible at the head the next cycle (1-cycle tuple latency).
// - States:
//   - WAIT_SOP: go = !empty.
//   - IN_PKT: go = 1.
// - Outputs:
//   - m_axis_tvalid = sdnet_tvalid & go.
//   - sdnet_tready = m_axis_tready & go.
//   - tdata/tkeep/tlast pass combinationally (0-cycle data latency).
// - m_axis_tuser = queue head in both states. Hold it unchanged until the tlast beat completes; it is 0 when the queue is empty.
// - Transitions:
//   - WAIT_SOP -> IN_PKT on a non-last beat handshake.
//   - IN_PKT -> WAIT_SOP on the tlast handshake.
//   - A single-beat packet (tlast on the first beat) stays in WAIT_SOP.
// - Pop: one pop per tlast handshake, same edge. pkt_cnt += 1 on that edge, wrapping 2^32-1 -> 0.
// - Push and pop in the same cycle: both occur and occupancy is unchanged. This holds when full, so no overflow.
// - Push while full without a pop: tuple discarded, tuple_ovfl <= 1, queue unchanged.
// - Packet beats before a tuple is available: stall (tready=0). Never emit a packet with an empty queue.
// - sdnet_tvalid deasserting mid-packet: allowed; state and tuser are held.
// - m_axis_tready low: tvalid stays asserted, tdata/tuser stable (AXIS rule).
// - Reset mid-packet: queue flushed, state WAIT_SOP. The packet remainder is blocked by tready=0 until a new tuple arrives. Upstream reset is coincident.
// - Width rule: tuser[47:0] = meta[47:0] (len, src, dst, drop, dig). tuser[303:48] = digest.
// STRUCTURE
// - Shared package / header (shared with the input-side adapter):
//   - MTPSA_META_W=128, MTPSA_DIGEST_W=256, MTPSA_KEEP_LO=48.
//   - Field offsets: PKT_LEN=0, SRC=16, DST=24, DROP=32, SEND_DIG=40.
// - One sub-module: mtpsa_tuple_fifo.
//   - Synchronous, 1-cycle write-to-read, head combinational.
//   - Signals: wr_en, rd_en, din, dout, empty, full.
//   - Pointers carry an extra wrap bit; full = MSBs differ, remaining bits equal.
// - Top: 2-state FSM, handshake gating, pkt_cnt, tuple_ovfl.
// TESTING
// - 1. Tuple first: meta_valid with meta[15:0]=0x0040, dst=0x04, digest=0xA5..A5, then a 2-beat packet with tready=1.
//   -> 2 beats out, tuser=={0xA5..A5, meta[47:0]} on both beats, pkt_cnt=1.
// - 2. Packet before tuple: sdnet_tvalid held 5 cycles, tuple on cycle 3.
//   -> tready/tvalid=0 on cycles 0-3, first beat accepted on cycle 4.
// - 3. Back-pressure: 4-beat packet, m_axis_tready toggling 1010...
//   -> no beat lost or duplicated; tuser/tdata stable while tvalid & !tready.
// - 4. Queue depth: 5 tuples with no packets.
//   -> tuple_ovfl=1, 4 entries held; then 4 single-beat packets out with tuples 0..3 in order.
// - 5. Push+pop when full: tuple pulse on the same cycle as a tlast handshake with 4 queued.
//   -> tuple_ovfl stays 0, occupancy stays 4.
// - 6. Reset mid-packet after beat 2 of 4.
//   -> next cycle tvalid=0, pkt_cnt=0, queue empty; a following tuple+packet passes with correct tuser.

Source files
------------

// File: rtl/mtpsa_from_sdnet_pkg.sv
// Shared MTPSA tuple layout used by the input- and output-side SDNet adapters.
package mtpsa_from_sdnet_pkg;

  localparam int MTPSA_META_W   = 128;
  localparam int MTPSA_DIGEST_W = 256;
  localparam int MTPSA_KEEP_LO  = 48;

  // Field offsets inside the retained low metadata bits.
  localparam int PKT_LEN  = 0;
  localparam int SRC      = 16;
  localparam int DST      = 24;
  localparam int DROP     = 32;
  localparam int SEND_DIG = 40;

  typedef logic [0:0] state_t;

  localparam state_t WAIT_SOP = 1'b0;
  localparam state_t IN_PKT   = 1'b1;

endpackage

// File: rtl/mtpsa_tuple_fifo.sv
// Small tuple queue: registered write, combinational head, wrap-bit pointers.
module mtpsa_tuple_fifo #(
  parameter int WIDTH = 304,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // A write into a full queue is legal only when the head leaves on the same edge.
  assign wr_ok = wr_en && (!full || rd_en);
  assign rd_ok = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/mtpsa_from_sdnet.sv
// Return-path adapter: pairs queued SDNet tuples with outgoing packets and
// holds tuser for the whole packet on the SUME master stream.
module mtpsa_from_sdnet
  import mtpsa_from_sdnet_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH    = 256,
  parameter int C_META_WIDTH         = MTPSA_META_W,
  parameter int DIGEST_WIDTH         = MTPSA_DIGEST_W,
  parameter int C_M_AXIS_TUSER_WIDTH = DIGEST_WIDTH + MTPSA_KEEP_LO,
  parameter int TUPLE_DEPTH          = 4
) (
  input  logic                              axis_aclk,
  input  logic                              axis_rst,
  input  logic                              sdnet_tvalid,
  input  logic                              sdnet_tlast,
  input  logic [C_AXIS_DATA_WIDTH-1:0]      sdnet_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]    sdnet_tkeep,
  output logic                              sdnet_tready,
  input  logic                              meta_valid,
  input  logic [C_META_WIDTH-1:0]           meta_data,
  input  logic [DIGEST_WIDTH-1:0]           digest_data,
  output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic                              tuple_ovfl,
  output logic [31:0]                       pkt_cnt
);

  state_t                          state;
  logic                            go;
  logic                            q_empty;
  logic                            q_full;
  logic                            beat_hs;
  logic                            last_hs;
  logic [C_M_AXIS_TUSER_WIDTH-1:0] q_head;
  logic                            meta_unused;

  assign meta_unused = ^meta_data[C_META_WIDTH-1:MTPSA_KEEP_LO];

  // A packet may only start once its tuple is at the head; reset blocks the stream outright.
  assign go = !axis_rst && ((state == IN_PKT) || !q_empty);

  assign m_axis_tvalid = sdnet_tvalid & go;
  assign sdnet_tready  = m_axis_tready & go;
  assign m_axis_tdata  = sdnet_tdata;
  assign m_axis_tkeep  = sdnet_tkeep;
  assign m_axis_tlast  = sdnet_tlast;
  assign m_axis_tuser  = q_empty ? '0 : q_head;

  assign beat_hs = m_axis_tvalid & m_axis_tready;
  assign last_hs = beat_hs & sdnet_tlast;

  mtpsa_tuple_fifo #(
    .WIDTH (C_M_AXIS_TUSER_WIDTH),
    .DEPTH (TUPLE_DEPTH)
  ) u_tuple_fifo (
    .clk   (axis_aclk),
    .rst   (axis_rst),
    .wr_en (meta_valid),
    .rd_en (last_hs),
    .din   ({digest_data, meta_data[MTPSA_KEEP_LO-1:0]}),
    .dout  (q_head),
    .empty (q_empty),
    .full  (q_full)
  );

  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      state <= WAIT_SOP;
    end else if (last_hs) begin
      state <= WAIT_SOP;
    end else if (beat_hs) begin
      state <= IN_PKT;
    end
  end

  // Overflow is only a drop when no tlast frees a slot on the same edge.
  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      pkt_cnt    <= '0;
      tuple_ovfl <= 1'b0;
    end else begin
      if (last_hs) begin
        pkt_cnt <= pkt_cnt + 32'd1;
      end
      if (meta_valid && q_full && !last_hs) begin
        tuple_ovfl <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mtpsa_from_sdnet.sv
// Self-checking bench for mtpsa_from_sdnet: vector table plus scoreboarded
// hand sequences for stall, back-pressure, queue depth and reset corners.
module tb_mtpsa_from_sdnet;

  localparam int DW = 256;
  localparam int KW = 32;
  localparam int MW = 128;
  localparam int GW = 256;
  localparam int UW = 304;

  logic          clk = 1'b0;
  logic          axis_rst;
  logic          sdnet_tvalid;
  logic          sdnet_tlast;
  logic [DW-1:0] sdnet_tdata;
  logic [KW-1:0] sdnet_tkeep;
  logic          sdnet_tready;
  logic          meta_valid;
  logic [MW-1:0] meta_data;
  logic [GW-1:0] digest_data;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic          tuple_ovfl;
  logic [31:0]   pkt_cnt;

  always #5 clk = ~clk;

  mtpsa_from_sdnet dut (
    .axis_aclk     (clk),
    .axis_rst      (axis_rst),
    .sdnet_tvalid  (sdnet_tvalid),
    .sdnet_tlast   (sdnet_tlast),
    .sdnet_tdata   (sdnet_tdata),
    .sdnet_tkeep   (sdnet_tkeep),
    .sdnet_tready  (sdnet_tready),
    .meta_valid    (meta_valid),
    .meta_data     (meta_data),
    .digest_data   (digest_data),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .tuple_ovfl    (tuple_ovfl),
    .pkt_cnt       (pkt_cnt)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [UW-1:0] tuser;
  } beat_t;

  typedef struct {
    logic [MW-1:0] meta;
    logic [GW-1:0] digest;
    int            beats;
    bit            bp;
    logic [UW-1:0] exp_tuser;
  } vec_t;

  beat_t         sb[$];
  beat_t         exp_beat;
  int            n_checks = 0;
  int            n_pass = 0;
  int            pkts_sent = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_data;
  logic [UW-1:0] stall_user;
  vec_t          vecs[4];
  logic [MW-1:0] t_meta[5];
  logic [GW-1:0] t_dig[5];
  logic [UW-1:0] t_exp[5];

  task automatic checkOutput(input string name, input logic [UW-1:0] act, input logic [UW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: pops the scoreboard on every accepted beat and checks AXIS hold rules.
  always @(negedge clk) begin
    if (axis_rst) begin
      sb.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checkOutput("hold_valid", UW'(m_axis_tvalid), UW'(1));
        checkOutput("hold_tdata", UW'(m_axis_tdata), UW'(stall_data));
        checkOutput("hold_tuser", m_axis_tuser, stall_user);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("[TB] FAIL unexpected_beat: got tdata %h, expected no beat", m_axis_tdata);
        end else begin
          exp_beat = sb.pop_front();
          checkOutput("beat_tdata", UW'(m_axis_tdata), UW'(exp_beat.data));
          checkOutput("beat_tkeep", UW'(m_axis_tkeep), UW'(exp_beat.keep));
          checkOutput("beat_tlast", UW'(m_axis_tlast), UW'(exp_beat.last));
          checkOutput("beat_tuser", m_axis_tuser, exp_beat.tuser);
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      stall_data = m_axis_tdata;
      stall_user = m_axis_tuser;
    end
  end

  task automatic pushTuple(input logic [MW-1:0] m, input logic [GW-1:0] d);
    meta_valid  = 1'b1;
    meta_data   = m;
    digest_data = d;
    tick();
    meta_valid  = 1'b0;
  endtask

  task automatic sendBeat(input logic last, input logic [UW-1:0] tuser, input bit bp);
    beat_t b;
    bit    acc;
    bit    done;
    b.data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    b.keep  = $urandom;
    b.last  = last;
    b.tuser = tuser;
    sb.push_back(b);
    sdnet_tvalid = 1'b1;
    sdnet_tdata  = b.data;
    sdnet_tkeep  = b.keep;
    sdnet_tlast  = last;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      acc = sdnet_tready && m_axis_tready;
      tick();
      if (bp) m_axis_tready = !m_axis_tready;
      if (acc) done = 1'b1;
    end
    if (!done) begin
      n_checks++;
      $display("[TB] FAIL beat_timeout: got no handshake in 40 cycles, expected one");
    end
  endtask

  task automatic sendPacket(input int beats, input logic [UW-1:0] tuser, input bit bp);
    m_axis_tready = 1'b1;
    for (int b = 0; b < beats; b++) sendBeat(b == beats - 1, tuser, bp);
    sdnet_tvalid  = 1'b0;
    m_axis_tready = 1'b1;
    pkts_sent++;
    tick();
  endtask

  task automatic applyStimulus(input vec_t v);
    pushTuple(v.meta, v.digest);
    sendPacket(v.beats, v.exp_tuser, v.bp);
    tick();
    @(negedge clk);
    checkOutput("pkt_cnt", UW'(pkt_cnt), UW'(pkts_sent));
    tick();
  endtask

  // Queue must be empty: an offered beat must stay blocked.
  task automatic checkEmpty(input string tag);
    sdnet_tvalid = 1'b1;
    sdnet_tlast  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput({tag, "_tvalid"}, UW'(m_axis_tvalid), UW'(0));
      checkOutput({tag, "_tready"}, UW'(sdnet_tready), UW'(0));
      tick();
    end
    sdnet_tvalid = 1'b0;
  endtask

  initial begin
    axis_rst      = 1'b1;
    sdnet_tvalid  = 1'b1;
    sdnet_tlast   = 1'b0;
    sdnet_tdata   = '0;
    sdnet_tkeep   = '0;
    meta_valid    = 1'b0;
    meta_data     = '0;
    digest_data   = '0;
    m_axis_tready = 1'b1;

    vecs[0].meta      = 128'hDEADBEEF_CAFEF00D_1234_0000_0400_0040;
    vecs[0].digest    = {32{8'hA5}};
    vecs[0].beats     = 2;
    vecs[0].bp        = 1'b0;
    vecs[0].exp_tuser = {{32{8'hA5}}, 48'h0000_0400_0040};
    vecs[1].meta      = 128'h11112222_33334444_5555_0101_0302_0080;
    vecs[1].digest    = {8{32'h0123_4567}};
    vecs[1].beats     = 4;
    vecs[1].bp        = 1'b1;
    vecs[1].exp_tuser = {{8{32'h0123_4567}}, 48'h0101_0302_0080};
    vecs[2].meta      = 128'hFFFFFFFF_FFFFFFFF_FFFF_0000_0000_0001;
    vecs[2].digest    = '0;
    vecs[2].beats     = 1;
    vecs[2].bp        = 1'b0;
    vecs[2].exp_tuser = {256'h0, 48'h0000_0000_0001};
    vecs[3].meta      = 128'h0_0000_0000_0000_0000_0100_FF07_05DC;
    vecs[3].digest    = {4{64'hFEDC_BA98_7654_3210}};
    vecs[3].beats     = 3;
    vecs[3].bp        = 1'b0;
    vecs[3].exp_tuser = {{4{64'hFEDC_BA98_7654_3210}}, 48'h0100_FF07_05DC};

    for (int k = 0; k < 5; k++) begin
      t_meta[k] = {$urandom, $urandom, $urandom, $urandom};
      t_dig[k]  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      t_exp[k]  = {t_dig[k], t_meta[k][47:0]};
    end

    // Reset cycle and the cycle after: stream blocked even with sdnet_tvalid high.
    tick();
    @(negedge clk);
    checkOutput("rst_tvalid", UW'(m_axis_tvalid), UW'(0));
    checkOutput("rst_tready", UW'(sdnet_tready), UW'(0));
    checkOutput("rst_pkt_cnt", UW'(pkt_cnt), UW'(0));
    checkOutput("rst_ovfl", UW'(tuple_ovfl), UW'(0));
    tick();
    axis_rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_tvalid", UW'(m_axis_tvalid), UW'(0));
    checkOutput("post_rst_tready", UW'(sdnet_tready), UW'(0));
    tick();
    sdnet_tvalid = 1'b0;
    tick();

    $display("[TB] vector table");
    for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

    $display("[TB] packet before tuple");
    begin
      beat_t b;
      b.data  = {8{32'h5A5A_0001}};
      b.keep  = 32'h0000_FFFF;
      b.last  = 1'b0;
      b.tuser = t_exp[0];
      sb.push_back(b);
      sdnet_tvalid = 1'b1;
      sdnet_tdata  = b.data;
      sdnet_tkeep  = b.keep;
      sdnet_tlast  = 1'b0;
      for (int c = 0; c < 5; c++) begin
        meta_valid  = (c == 3);
        meta_data   = t_meta[0];
        digest_data = t_dig[0];
        @(negedge clk);
        checkOutput($sformatf("stall_tready_c%0d", c), UW'(sdnet_tready), UW'(c == 4));
        checkOutput($sformatf("stall_tvalid_c%0d", c), UW'(m_axis_tvalid), UW'(c == 4));
        tick();
      end
      meta_valid = 1'b0;
      sendBeat(1'b1, t_exp[0], 1'b0);
      sdnet_tvalid = 1'b0;
      pkts_sent++;
      tick();
    end

    $display("[TB] push and pop while full");
    for (int k = 0; k < 4; k++) pushTuple(t_meta[k], t_dig[k]);
    begin
      beat_t b;
      b.data  = {8{32'hC0DE_0005}};
      b.keep  = 32'hFFFF_FFFF;
      b.last  = 1'b1;
      b.tuser = t_exp[0];
      sb.push_back(b);
      sdnet_tvalid = 1'b1;
      sdnet_tdata  = b.data;
      sdnet_tkeep  = b.keep;
      sdnet_tlast  = 1'b1;
      meta_valid   = 1'b1;
      meta_data    = t_meta[4];
      digest_data  = t_dig[4];
      @(negedge clk);
      checkOutput("pushpop_tready", UW'(sdnet_tready), UW'(1));
      tick();
      meta_valid   = 1'b0;
      sdnet_tvalid = 1'b0;
      pkts_sent++;
      @(negedge clk);
      checkOutput("pushpop_ovfl", UW'(tuple_ovfl), UW'(0));
      tick();
    end
    for (int k = 1; k < 5; k++) sendPacket(1, t_exp[k], 1'b0);
    checkEmpty("pushpop_drained");

    $display("[TB] queue depth");
    for (int k = 0; k < 5; k++) pushTuple(t_meta[k], t_dig[k]);
    @(negedge clk);
    checkOutput("depth_ovfl", UW'(tuple_ovfl), UW'(1));
    tick();
    for (int k = 0; k < 4; k++) sendPacket(1, t_exp[k], 1'b0);
    checkEmpty("depth_drained");
    @(negedge clk);
    checkOutput("depth_pkt_cnt", UW'(pkt_cnt), UW'(pkts_sent));
    tick();

    $display("[TB] reset mid-packet");
    pushTuple(t_meta[2], t_dig[2]);
    sdnet_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    sendBeat(1'b0, t_exp[2], 1'b0);
    sendBeat(1'b0, t_exp[2], 1'b0);
    sdnet_tdata = {8{32'hBAD0_0003}};
    sdnet_tlast = 1'b0;
    axis_rst    = 1'b1;
    @(negedge clk);
    checkOutput("midrst_tvalid", UW'(m_axis_tvalid), UW'(0));
    tick();
    axis_rst  = 1'b0;
    pkts_sent = 0;
    @(negedge clk);
    checkOutput("midrst_next_tvalid", UW'(m_axis_tvalid), UW'(0));
    checkOutput("midrst_pkt_cnt", UW'(pkt_cnt), UW'(0));
    checkOutput("midrst_ovfl", UW'(tuple_ovfl), UW'(0));
    tick();
    checkEmpty("midrst_empty");
    applyStimulus(vecs[3]);

    checkOutput("sb_drained", UW'(sb.size()), UW'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got no finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
